uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning width of the baud divisor input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port cfg_div  input  DIV_WIDTH  clk cycles per bit (legal >=4); sampled at each start-bit detection.
REQ-008 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port m_ready  input  1  consumer accepts m_data when m_valid.
REQ-010 SHALL have port m_data  output  DATA_BITS  oldest FIFO entry.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all timing below is relative to the synchronized signal rxs.
REQ-015 SHALL implement FSM states IDLE, START, DATA, (PARITY), STOP.
REQ-016 IDLE->START SHALL occur on the first cycle rxs==0; the bit counter loads cfg_div>>1.
REQ-017 In START at counter expiry: rxs==0 -> DATA with counter reloaded to cfg_div; rxs==1 -> IDLE, treated as a glitch with no output.
REQ-018 DATA SHALL sample rxs every cfg_div cycles, shifting in LSB first, for DATA_BITS samples, then go to PARITY (if compiled in) or STOP.
REQ-019 STOP SHALL sample after cfg_div cycles: rxs==1 -> push; rxs==0 -> frame_err pulse and discard; both cases return to IDLE.
REQ-020 SHALL not re-detect a start bit until rxs has been seen high once in IDLE (break/stuck-low line yields one frame_err only).
REQ-021 Push SHALL occur on the stop-sample edge; m_valid SHALL be high the next cycle (latency is 1 cycle from stop sample).
REQ-022 Pop SHALL occur on any cycle with m_valid && m_ready; m_data SHALL show the next entry the following cycle.
REQ-023 If push and pop happen in the same cycle, fifo_level SHALL be unchanged, and the push SHALL be accepted even when full.
REQ-024 If push happens when full without a pop, the frame SHALL be dropped, overrun SHALL pulse, and the FIFO contents SHALL stay intact.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL saturate at neither end (it is always exact).
REQ-026 frame_err and overrun SHALL never assert in the same cycle as a successful push.

Reset
REQ-027 With resetn low: FSM=IDLE, FIFO empty, m_valid=0, m_data=0, fifo_level=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push and no error pulse after release.

Configuration
REQ-029 With UART_RX_PARITY_EN defined, SHALL add input cfg_parity_odd (1 bit) and state PARITY, which samples one bit cfg_div cycles after the last data bit.
REQ-030 In that case, a parity mismatch SHALL pulse output parity_err for one cycle, discard the frame, and still check the stop bit (frame_err may also pulse at the stop sample).
REQ-031 Without UART_RX_PARITY_EN, cfg_parity_odd, parity_err and the PARITY state SHALL be absent and frames SHALL be start+DATA_BITS+stop.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state enum and the constant MIN_DIV=4.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH), reusable elsewhere in the SoC.

Verification
REQ-034 cfg_div=106, send 0x41 -> m_valid rises 1 cycle after the stop sample, m_data=0x41, fifo_level=1; pop -> level 0.
REQ-035 cfg_div=106, rx low for 20 cycles then high -> no push, no frame_err, FSM back in IDLE.
REQ-036 Send 0x55 with stop bit 0 -> frame_err pulses once, fifo_level stays 0; rx held low 5000 cycles -> no further frame_err.
REQ-037 FIFO_DEPTH=16, m_ready=0, send 17 bytes 0x00..0x10 -> level 16, overrun pulses once, pops return 0x00..0x0F in order.
REQ-038 Full FIFO with m_ready=1 at the 17th stop sample -> level stays 16, no overrun, 0x10 is the last entry read.
REQ-039 UART_RX_PARITY_EN, cfg_parity_odd=0, send 0x07 with parity 0 -> parity_err pulses, no push; reset pulse mid-DATA -> level 0, no pulses after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and the minimum legal baud divisor.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the oldest entry and an exact occupancy count.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign level    = count;
  // An empty FIFO presents zero rather than stale storage.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + DATA_BITS LSB-first + optional parity + stop) feeding a receive FIFO.
// Define UART_RX_PARITY_EN to add the parity bit, cfg_parity_odd and parity_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
`ifdef UART_RX_PARITY_EN
  input  logic                          cfg_parity_odd,
  output logic                          parity_err,
`endif
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output uart_state_e                   dbg_state
);

  localparam int BW = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 rxs;
  uart_state_e          state;
  uart_state_e          state_next;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_in;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 par_bad;
  logic                 tick;
  logic                 last_bit;
  logic                 start_det;
  logic                 push;
  logic                 ferr_c;
  logic                 perr_c;
  logic                 fifo_full;

  // Two-flop synchronizer; reset to the idle-high line level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  assign div_in    = (cfg_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_div;
  assign tick      = (cnt <= DIV_WIDTH'(1));
  assign last_bit  = (bit_idx == BW'(DATA_BITS - 1));
  // armed drops after a low stop bit so a held-low line cannot start another frame.
  assign start_det = (state == IDLE) && armed && !rxs;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start_det) state_next = START;
      START:  if (tick) state_next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (tick && last_bit) state_next = PARITY;
      PARITY: if (tick) state_next = STOP;
`else
      DATA:   if (tick && last_bit) state_next = STOP;
`endif
      STOP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push   = 1'b0;
    ferr_c = 1'b0;
    perr_c = 1'b0;
    unique case (state)
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) perr_c = (rxs != ((^shreg) ^ cfg_parity_odd));
`endif
      STOP: begin
        if (tick) begin
          push   = rxs && !par_bad;
          ferr_c = !rxs;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      div_q   <= DIV_WIDTH'(MIN_DIV);
      bit_idx <= '0;
      shreg   <= '0;
      armed   <= 1'b1;
    end else begin
      if (state == IDLE) begin
        if (rxs) armed <= 1'b1;
        if (start_det) begin
          div_q   <= div_in;
          cnt     <= div_in >> 1;
          bit_idx <= '0;
        end
      end else begin
        cnt <= tick ? div_q : cnt - DIV_WIDTH'(1);
      end
      if (state == DATA && tick) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= last_bit ? '0 : bit_idx + BW'(1);
      end
      if (state == STOP && tick && !rxs) armed <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_c;
      if (state == PARITY && tick) par_bad <= perr_c;
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // A full FIFO still takes the frame when the consumer pops in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_c;
      overrun   <= push && fifo_full && !m_ready;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (shreg),
    .pop       (m_ready),
    .pop_data  (m_data),
    .valid     (m_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule
